// File: rtl/dp_lane_tx_pkg.sv
// Shared definitions for the DisplayPort transmit lane stage: mode codes,
// link symbols, TPS2 period, PRBS7 seed and the 16-bit PRBS7 step.
package dp_lane_tx_pkg;

  localparam logic [2:0] PHYMODE_IDLE  = 3'd0;
  localparam logic [2:0] PHYMODE_DATA  = 3'd1;
  localparam logic [2:0] PHYMODE_TPS1  = 3'd2;
  localparam logic [2:0] PHYMODE_TPS2  = 3'd3;
  localparam logic [2:0] PHYMODE_PRBS7 = 3'd4;

  localparam logic [7:0] SYM_D10_2 = 8'h4A;
  localparam logic [7:0] SYM_K28_5 = 8'hBC;
  localparam logic [7:0] SYM_D11_6 = 8'hCB;

  localparam logic [2:0] TPS2_PERIOD = 3'd5;
  localparam logic [6:0] PRBS7_SEED  = 7'h7F;

  typedef struct packed {
    logic [1:0]  isk;
    logic [15:0] dat;
  } lane_word_t;

  // Advances x^7+x^6+1 by 16 bits; first bit lands in bit 0. Returns {state, word}.
  function automatic logic [22:0] prbs7_step16(input logic [6:0] seed);
    logic [6:0]  s;
    logic [15:0] w;
    logic        b;
    s = seed;
    w = 16'h0000;
    for (int j = 0; j < 16; j++) begin
      b    = s[6] ^ s[5];
      w[j] = b;
      s    = {s[5:0], b};
    end
    return {s, w};
  endfunction

endpackage

// File: rtl/dp_skew_line.sv
// Fixed-depth registered delay line used for inter-lane skew; DEPTH=0 is a
// plain wire.
module dp_skew_line #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign q = d;
    end else begin : g_reg
      logic [WIDTH-1:0] sr [DEPTH];

      // Shift every cycle, independent of link mode
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
        end else begin
          sr[0] <= d;
          for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
        end
      end

      assign q = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/dp_lane_tx.sv
// DisplayPort main-link transmit lane stage: per-lane pattern mux plus fixed
// inter-lane skew. Optional PRBS7 generator in mode 4 when DP_PRBS7_EN is defined.
module dp_lane_tx
  import dp_lane_tx_pkg::*;
#(
  parameter int NLANES = 4,
  parameter int SKEW   = 2
) (
  input  logic                  dpclk,
  input  logic                  reset,
  input  logic [2:0]            phymode,
  input  logic [16*NLANES-1:0]  scrdat,
  input  logic [2*NLANES-1:0]   scrisk,
  output logic [16*NLANES-1:0]  txdat,
  output logic [2*NLANES-1:0]   txisk,
  output logic                  modechg
);

  logic [2:0]  prevmode;
  logic [2:0]  ctr;
  logic        chg;
  logic [2:0]  eff_ctr;
  logic [2:0]  ctr_next;
  logic [15:0] prbs_word;
  lane_word_t  pat;
  lane_word_t [NLANES-1:0] stage;

  // Mode-change detect and pattern position; a new mode always starts at 0
  always_comb begin
    chg      = (phymode != prevmode);
    eff_ctr  = chg ? 3'd0 : ctr;
    if (chg) begin
      ctr_next = 3'd1;
    end else if (ctr == (TPS2_PERIOD - 3'd1)) begin
      ctr_next = 3'd0;
    end else begin
      ctr_next = ctr + 3'd1;
    end
  end

`ifdef DP_PRBS7_EN
  logic [6:0]  prbs;
  logic [6:0]  prbs_start;
  logic [22:0] prbs_step;

  // Seed is reloaded on entry to mode 4 so the first word comes from 7'h7F
  always_comb begin
    prbs_start = chg ? PRBS7_SEED : prbs;
    prbs_step  = prbs7_step16(prbs_start);
    prbs_word  = prbs_step[15:0];
  end

  // PRBS state only advances while mode 4 is active
  always_ff @(posedge dpclk or posedge reset) begin
    if (reset) begin
      prbs <= PRBS7_SEED;
    end else if (phymode == PHYMODE_PRBS7) begin
      prbs <= prbs_step[22:16];
    end else begin
      prbs <= prbs;
    end
  end
`else
  assign prbs_word = 16'h0000;
`endif

  // Pattern shared by all lanes for the non-data modes
  always_comb begin
    pat = '0;
    case (phymode)
      PHYMODE_TPS1:  pat = {2'b00, SYM_D10_2, SYM_D10_2};
      PHYMODE_TPS2: begin
        if (eff_ctr < 3'd2) begin
          pat = {2'b01, SYM_D11_6, SYM_K28_5};
        end else begin
          pat = {2'b00, SYM_D10_2, SYM_D10_2};
        end
      end
      PHYMODE_PRBS7: pat = {2'b00, prbs_word};
      default:       pat = '0;
    endcase
  end

  // Stage 1: registered per-lane word and mode-change tracking
  always_ff @(posedge dpclk or posedge reset) begin
    if (reset) begin
      prevmode <= 3'd0;
      ctr      <= 3'd0;
      modechg  <= 1'b0;
      stage    <= '0;
    end else begin
      prevmode <= phymode;
      ctr      <= ctr_next;
      modechg  <= chg;
      for (int i = 0; i < NLANES; i++) begin
        if (phymode == PHYMODE_DATA) begin
          stage[i] <= {scrisk[2*i +: 2], scrdat[16*i +: 16]};
        end else begin
          stage[i] <= pat;
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < NLANES; i++) begin : g_lane
      logic [17:0] lane_q;

      dp_skew_line #(
        .DEPTH (i * SKEW),
        .WIDTH (18)
      ) u_skew (
        .clk   (dpclk),
        .reset (reset),
        .d     (stage[i]),
        .q     (lane_q)
      );

      assign txdat[16*i +: 16] = lane_q[15:0];
      assign txisk[2*i +: 2]   = lane_q[17:16];
    end
  endgenerate

endmodule
